// File: rtl/test_status_dev.sv
// Simulation-control peripheral: decodes TOHOST pass/fail writes, tracks the case number, runs a cycle watchdog.
// Latency: writes act on the request edge; read data and status outputs are registered one cycle later.
// Backpressure: none, the bus is always ready and every read request gets exactly one rvalid pulse.
module test_status_dev #(
  parameter int unsigned TIMEOUT_CYCLES = 4000,
  parameter int unsigned TNUM_W         = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              bus_req,
  input  logic              bus_write,
  input  logic [3:0]        bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_rdata,
  output logic              bus_rvalid,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [TNUM_W-1:0] test_num
);

  // The state encoding doubles as the STATUS[1:0] code seen by firmware.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } state_t;

  localparam logic        LP_WDOG_EN   = (TIMEOUT_CYCLES != 0);
  // Counter value seen on the edge that completes cycle TIMEOUT_CYCLES.
  localparam logic [31:0] LP_TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0]  LP_A_TOHOST  = 2'd0;
  localparam logic [1:0]  LP_A_CASE    = 2'd1;
  localparam logic [1:0]  LP_A_STATUS  = 2'd2;
  localparam logic [1:0]  LP_A_CYCLE   = 2'd3;

  state_t              r_state;
  logic [31:0]         r_cycle;
  logic [TNUM_W-1:0]   r_test_num;
  logic                r_rvalid;
  logic [31:0]         r_rdata;
  logic                r_done;
  logic                r_pass;
  logic                r_fail;
  logic                r_timeout;

  state_t              w_state_nxt;
  logic [31:0]         w_cycle_nxt;
  logic [TNUM_W-1:0]   w_tnum_nxt;
  logic [31:0]         w_rdata_nxt;
  logic                w_rd;
  logic                w_wr_ok;
  logic                w_sel_tohost;
  logic                w_sel_case;
  logic                w_tohost_pass;
  logic                w_tohost_fail;
  logic                w_case_wr;
  logic                w_tmo_hit;
  logic [15:0]         w_tnum16;
  logic                w_unused_addr;

  // Byte-lane bits of the address carry no meaning for word registers.
  assign w_unused_addr = ^bus_addr[1:0];

  // Partial-word writes are dropped entirely.
  assign w_rd          = bus_req & ~bus_write;
  assign w_wr_ok       = bus_req & bus_write & (bus_wstrb == 4'hF);
  assign w_sel_tohost  = (bus_addr[3:2] == LP_A_TOHOST);
  assign w_sel_case    = (bus_addr[3:2] == LP_A_CASE);

  // TOHOST decode: 1 means pass, any other odd value is a failure code; even values are reserved.
  assign w_tohost_pass = w_wr_ok & w_sel_tohost & (bus_wdata == 32'd1);
  assign w_tohost_fail = w_wr_ok & w_sel_tohost & bus_wdata[0] & (bus_wdata != 32'd1);
  assign w_case_wr     = w_wr_ok & w_sel_case;

  // Compare against the pre-increment count so TMO lands on the edge that finishes cycle TIMEOUT_CYCLES.
  assign w_tmo_hit     = LP_WDOG_EN && (r_cycle == LP_TMO_LAST);

  assign w_tnum16      = 16'(r_test_num);

  // Next state: firmware verdict beats the watchdog on a shared edge; terminal states hold.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN) begin
      if (w_tohost_pass) begin
        w_state_nxt = ST_PASS;
      end else if (w_tohost_fail) begin
        w_state_nxt = ST_FAIL;
      end else if (w_tmo_hit) begin
        w_state_nxt = ST_TMO;
      end
    end
  end

  // Test number: the failure code from TOHOST overrides a CASE write; frozen outside RUN.
  always_comb begin
    w_tnum_nxt = r_test_num;
    if (r_state == ST_RUN) begin
      if (w_tohost_fail) begin
        w_tnum_nxt = bus_wdata[TNUM_W:1];
      end else if (w_case_wr) begin
        w_tnum_nxt = bus_wdata[TNUM_W-1:0];
      end
    end
  end

  // Cycle counter: counts only while in RUN and sticks at all-ones instead of wrapping.
  always_comb begin
    w_cycle_nxt = r_cycle;
    if ((r_state == ST_RUN) && (r_cycle != 32'hFFFF_FFFF)) begin
      w_cycle_nxt = r_cycle + 32'd1;
    end
  end

  // Read mux: write-only registers read back as zero.
  always_comb begin
    w_rdata_nxt = 32'd0;
    case (bus_addr[3:2])
      LP_A_STATUS: w_rdata_nxt = {w_tnum16, 14'd0, r_state};
      LP_A_CYCLE:  w_rdata_nxt = r_cycle;
      default:     w_rdata_nxt = 32'd0;
    endcase
  end

  // Core state, counter and test number registers.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state    <= ST_RUN;
      r_cycle    <= 32'd0;
      r_test_num <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cycle    <= w_cycle_nxt;
      r_test_num <= w_tnum_nxt;
    end
  end

  // Read response: one rvalid pulse per read request; data holds between reads.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rdata_nxt;
      end
    end
  end

  // Verdict outputs registered from the next state so they appear the cycle after the deciding edge.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_pass    <= (w_state_nxt == ST_PASS);
      r_fail    <= (w_state_nxt == ST_FAIL);
      r_timeout <= (w_state_nxt == ST_TMO);
      r_done    <= (w_state_nxt != ST_RUN);
    end
  end

  assign bus_rdata  = r_rdata;
  assign bus_rvalid = r_rvalid;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign timeout    = r_timeout;
  assign test_num   = r_test_num;

endmodule
